unidade_entrada: RTL

UNIDADE_ENTRADA -- requirements
Module: unidade_entrada

---
 rtl/pkg_entrada_saida.sv | 14 +
 rtl/filtro_botao.sv | 61 ++++++
 rtl/unidade_entrada.sv | 93 +++++++++
 3 files changed

// File: rtl/pkg_entrada_saida.sv
// Shared definitions for the switch/button input unit: FSM encodings and default sizes.
package pkg_entrada_saida;

   localparam int DEBOUNCE_PADRAO = 50000;
   localparam int DADO_W          = 32;

   typedef enum logic [1:0] {
      OCIOSO         = 2'd0,
      ESPERA_PRESSAO = 2'd1,
      ESPERA_SOLTURA = 2'd2,
      ENTREGA        = 2'd3
   } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Confirm-key conditioning: 2-flop synchronizer, debounce counter and one-cycle
// press/release pulses of the debounced level (active-low key, 1 = pressed internally).
module filtro_botao
   import pkg_entrada_saida::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_botao,
   output logic o_borda_pressao,
   output logic o_borda_soltura
);

   localparam int             CONT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CYCLES);

   logic              r_sinc1;
   logic              r_sinc2;
   logic              r_estavel;
   logic [CONT_W-1:0] r_cont;
   logic              r_borda_pressao;
   logic              r_borda_soltura;

   logic              w_pressionado;
   logic [CONT_W-1:0] w_cont_prox;

   assign w_pressionado = ~r_sinc2;
   // Saturating increment: the counter can never wrap even if held at its limit.
   assign w_cont_prox   = (r_cont == CONT_MAX) ? r_cont : r_cont + CONT_W'(1);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sinc1         <= 1'b1;
         r_sinc2         <= 1'b1;
         r_estavel       <= 1'b0;
         r_cont          <= '0;
         r_borda_pressao <= 1'b0;
         r_borda_soltura <= 1'b0;
      end else begin
         r_sinc1         <= i_botao;
         r_sinc2         <= r_sinc1;
         r_borda_pressao <= 1'b0;
         r_borda_soltura <= 1'b0;
         if (w_pressionado == r_estavel) begin
            r_cont <= '0;
         end else if (w_cont_prox == CONT_MAX) begin
            r_estavel       <= w_pressionado;
            r_cont          <= '0;
            r_borda_pressao <= w_pressionado;
            r_borda_soltura <= ~w_pressionado;
         end else begin
            r_cont <= w_cont_prox;
         end
      end
   end

   assign o_borda_pressao = r_borda_pressao;
   assign o_borda_soltura = r_borda_soltura;

endmodule

// File: rtl/unidade_entrada.sv
// Processor input unit: on request, waits for a debounced key press, latches the
// switches, waits for release and pulses pronto while stalling the processor.
module unidade_entrada
   import pkg_entrada_saida::*;
#(
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pedido,
   input  logic [SW_WIDTH-1:0] chaves,
   input  logic                botao,
   output logic [DADO_W-1:0]   dado,
   output logic                pronto,
   output logic                aguardando
);

   estado_t             r_estado;
   logic [DADO_W-1:0]   r_dado;
   logic                r_pronto;
   logic                r_aguardando;
   logic [SW_WIDTH-1:0] r_chaves_s1;
   logic [SW_WIDTH-1:0] r_chaves_s2;

   logic                w_borda_pressao;
   logic                w_borda_soltura;

   filtro_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_filtro (
      .i_clock         (clock),
      .i_reset         (reset),
      .i_botao         (botao),
      .o_borda_pressao (w_borda_pressao),
      .o_borda_soltura (w_borda_soltura)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_chaves_s1 <= '0;
         r_chaves_s2 <= '0;
      end else begin
         r_chaves_s1 <= chaves;
         r_chaves_s2 <= r_chaves_s1;
      end
   end

   // Only a press edge seen while waiting counts, so a key already held is never captured.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado     <= OCIOSO;
         r_dado       <= '0;
         r_pronto     <= 1'b0;
         r_aguardando <= 1'b0;
      end else begin
         r_pronto <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (pedido) begin
                  r_estado     <= ESPERA_PRESSAO;
                  r_aguardando <= 1'b1;
               end
            end
            ESPERA_PRESSAO: begin
               if (w_borda_pressao) begin
                  r_dado   <= DADO_W'(r_chaves_s2);
                  r_estado <= ESPERA_SOLTURA;
               end
            end
            ESPERA_SOLTURA: begin
               if (w_borda_soltura) begin
                  r_estado     <= ENTREGA;
                  r_aguardando <= 1'b0;
                  r_pronto     <= 1'b1;
               end
            end
            ENTREGA: begin
               r_estado <= OCIOSO;
            end
            default: begin
               r_estado     <= OCIOSO;
               r_aguardando <= 1'b0;
            end
         endcase
      end
   end

   assign dado       = r_dado;
   assign pronto     = r_pronto;
   assign aguardando = r_aguardando;

endmodule
